// File: rtl/conf_int_mac_pipe.sv
// Three-stage configurable-precision integer multiply-accumulate pipeline.
// Stage 1 latches the four split partial products, stage 2 combines them
// under the precision mode, and stage 3 adds c or the running accumulator.
// Every stage advances together and holds as a unit while the consumer stalls.
module conf_int_mac_pipe #(
    parameter int OP_BITWIDTH  = 32,
    parameter int Pn           = 12,
    parameter int ACC_BITWIDTH = 32
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [OP_BITWIDTH-1:0]  a,
    input  logic [OP_BITWIDTH-1:0]  b,
    input  logic [ACC_BITWIDTH-1:0] c,
    input  logic [1:0]              prec_mode,
    input  logic                    acc_en,
    input  logic                    acc_clr,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [ACC_BITWIDTH-1:0] d
);

    localparam int HW = OP_BITWIDTH - Pn;
    // The full product is 2*OP_BITWIDTH wide; summing at that width (or
    // ACC_BITWIDTH if larger) and truncating gives the modulo result.
    localparam int SW = (2 * OP_BITWIDTH > ACC_BITWIDTH) ? 2 * OP_BITWIDTH : ACC_BITWIDTH;

    logic adv;

    logic [Pn-1:0] a_l, b_l;
    logic [HW-1:0] a_h, b_h;
    logic [2*Pn-1:0]        ll_p;
    logic [OP_BITWIDTH-1:0] hl_p, lh_p;
    logic [2*HW-1:0]        hh_p;

    logic                    v1;
    logic [2*Pn-1:0]         ll_r;
    logic [OP_BITWIDTH-1:0]  hl_r, lh_r;
    logic [2*HW-1:0]         hh_r;
    logic [1:0]              mode1;
    logic                    acc_en1, acc_clr1;
    logic [ACC_BITWIDTH-1:0] c1;

    logic [SW-1:0]           ll_x, hl_x, lh_x, hh_x, sum_w;
    logic [ACC_BITWIDTH-1:0] mul_c;

    logic                    v2;
    logic [ACC_BITWIDTH-1:0] mul2, c2;
    logic                    acc_en2, acc_clr2;

    logic [ACC_BITWIDTH-1:0] acc, acc_next, plain_sum;

    // A stalled result blocks the whole pipe; no bubble squeezing.
    assign adv      = !(out_valid && !out_ready);
    assign in_ready = rst && adv;

    assign a_l = a[Pn-1:0];
    assign b_l = b[Pn-1:0];
    assign a_h = a[OP_BITWIDTH-1:Pn];
    assign b_h = b[OP_BITWIDTH-1:Pn];

    // Full-width partial products, operands zero-extended to the result width.
    always_comb begin
        ll_p = {{Pn{1'b0}}, a_l} * {{Pn{1'b0}}, b_l};
        hl_p = {{Pn{1'b0}}, a_h} * {{HW{1'b0}}, b_l};
        lh_p = {{HW{1'b0}}, a_l} * {{Pn{1'b0}}, b_h};
        hh_p = {{HW{1'b0}}, a_h} * {{HW{1'b0}}, b_h};
    end

    // Valid bits of every stage; reset discards anything in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
        end else if (adv) begin
            v1 <= in_valid;
            v2 <= v1;
        end
    end

    // Stage 1 and stage 2 payload; qualified by the valid bits, so no reset.
    always_ff @(posedge clk) begin
        if (adv) begin
            ll_r     <= ll_p;
            hl_r     <= hl_p;
            lh_r     <= lh_p;
            hh_r     <= hh_p;
            mode1    <= prec_mode;
            acc_en1  <= acc_en;
            acc_clr1 <= acc_clr;
            c1       <= c;
            mul2     <= mul_c;
            c2       <= c1;
            acc_en2  <= acc_en1;
            acc_clr2 <= acc_clr1;
        end
    end

    // Recombine the partial products, zeroing those the precision mode drops.
    always_comb begin
        ll_x  = (mode1 == 2'd0) ? SW'(ll_r) : '0;
        hl_x  = mode1[1] ? '0 : (SW'(hl_r) << Pn);
        lh_x  = mode1[1] ? '0 : (SW'(lh_r) << Pn);
        hh_x  = SW'(hh_r) << (2 * Pn);
        sum_w = hh_x + lh_x + hl_x + ll_x;
        mul_c = sum_w[ACC_BITWIDTH-1:0];
    end

    // Stage 3 sums: accumulator path and plain product-plus-addend path.
    always_comb begin
        acc_next  = (acc_clr2 ? c2 : acc) + mul2;
        plain_sum = mul2 + c2;
    end

    // Result and accumulator; the accumulator moves once per beat leaving stage 2.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            d         <= '0;
            acc       <= '0;
        end else if (adv) begin
            out_valid <= v2;
            if (v2) begin
                if (acc_en2) begin
                    acc <= acc_next;
                    d   <= acc_next;
                end else begin
                    d   <= plain_sum;
                end
            end
        end
    end

endmodule

// File: tb/tb_conf_int_mac_pipe.sv
// Directed bench for conf_int_mac_pipe with hand-computed expected values.
module tb_conf_int_mac_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a, b, c;
    logic [1:0]  prec_mode;
    logic        acc_en, acc_clr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] d;

    int checks = 0;
    int errors = 0;

    conf_int_mac_pipe #(.OP_BITWIDTH(32), .Pn(12), .ACC_BITWIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .c(c), .prec_mode(prec_mode), .acc_en(acc_en),
        .acc_clr(acc_clr), .out_valid(out_valid), .out_ready(out_ready), .d(d)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, cross the rising edge, settle 1 time unit.
    task automatic cyc(input logic v, input logic [31:0] ia, input logic [31:0] ib,
                       input logic [31:0] ic, input logic [1:0] m,
                       input logic en, input logic clr);
        in_valid  = v;
        a         = ia;
        b         = ib;
        c         = ic;
        prec_mode = m;
        acc_en    = en;
        acc_clr   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 32'd0, 32'd0, 32'd0, 2'd0, 1'b0, 1'b0);
    endtask

    initial begin
        rst = 1'b0; out_ready = 1'b1;
        in_valid = 1'b0; a = '0; b = '0; c = '0; prec_mode = '0; acc_en = 1'b0; acc_clr = 1'b0;
        #2;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd0);
        idle();
        idle();
        chk("reset_out_valid", {31'd0, out_valid}, 32'd0);
        chk("reset_d", d, 32'd0);
        rst = 1'b1;
        #1;
        chk("in_ready_after_reset", {31'd0, in_ready}, 32'd1);

        // Exact mode, three-edge latency, single-cycle out_valid pulse
        cyc(1'b1, 32'h1234, 32'h10, 32'd5, 2'd0, 1'b0, 1'b0);
        idle();
        chk("exact_not_early", {31'd0, out_valid}, 32'd0);
        idle();
        chk("exact_valid", {31'd0, out_valid}, 32'd1);
        chk("exact_d", d, 32'h12345);
        idle();
        chk("exact_pulse_end", {31'd0, out_valid}, 32'd0);
        chk("exact_d_hold", d, 32'h12345);

        // Precision modes back-to-back
        cyc(1'b1, 32'h3001, 32'h2001, 32'd0, 2'd0, 1'b0, 1'b0);
        cyc(1'b1, 32'h3001, 32'h2001, 32'd0, 2'd1, 1'b0, 1'b0);
        cyc(1'b1, 32'h3001, 32'h2001, 32'd0, 2'd2, 1'b0, 1'b0);
        chk("prec_mode0", d, 32'h6005001);
        cyc(1'b1, 32'h1FFF, 32'hFFF, 32'd0, 2'd1, 1'b0, 1'b0);
        chk("prec_mode1", d, 32'h6005000);
        idle();
        chk("prec_mode2", d, 32'h6000000);
        idle();
        chk("prec_mode1_b", d, 32'hFFF000);
        chk("prec_valid", {31'd0, out_valid}, 32'd1);
        idle();
        chk("prec_drain", {31'd0, out_valid}, 32'd0);

        // Accumulate chain, then a non-accumulating beat, then read acc back
        cyc(1'b1, 32'd2, 32'd3, 32'd10, 2'd0, 1'b1, 1'b1);
        cyc(1'b1, 32'd4, 32'd5, 32'd0, 2'd0, 1'b1, 1'b0);
        cyc(1'b1, 32'd1, 32'd1, 32'd0, 2'd0, 1'b1, 1'b0);
        chk("acc_seed", d, 32'd16);
        cyc(1'b1, 32'd7, 32'd7, 32'd1, 2'd0, 1'b0, 1'b0);
        chk("acc_chain1", d, 32'd36);
        cyc(1'b1, 32'd0, 32'd0, 32'd0, 2'd0, 1'b1, 1'b0);
        chk("acc_chain2", d, 32'd37);
        idle();
        chk("acc_bypass", d, 32'd50);
        idle();
        chk("acc_kept", d, 32'd37);
        idle();

        // Backpressure: out_ready low for 6 cycles
        out_ready = 1'b0;
        cyc(1'b1, 32'd1, 32'd1, 32'd0, 2'd0, 1'b0, 1'b0);
        cyc(1'b1, 32'd2, 32'd2, 32'd0, 2'd0, 1'b0, 1'b0);
        cyc(1'b1, 32'd3, 32'd3, 32'd0, 2'd0, 1'b0, 1'b0);
        chk("bp_first_valid", {31'd0, out_valid}, 32'd1);
        chk("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        chk("bp_first_d", d, 32'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 32'd4, 32'd4, 32'd0, 2'd0, 1'b0, 1'b0);
            chk("bp_stall_ready", {31'd0, in_ready}, 32'd0);
            chk("bp_stall_valid", {31'd0, out_valid}, 32'd1);
            chk("bp_stall_d", d, 32'd1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, in_ready}, 32'd1);
        cyc(1'b1, 32'd4, 32'd4, 32'd0, 2'd0, 1'b0, 1'b0);
        chk("bp_d2", d, 32'd4);
        idle();
        chk("bp_d3", d, 32'd9);
        idle();
        chk("bp_d4", d, 32'd16);
        chk("bp_d4_valid", {31'd0, out_valid}, 32'd1);
        idle();
        chk("bp_no_repeat", {31'd0, out_valid}, 32'd0);

        // Reset mid-operation discards in-flight beats and clears the accumulator
        cyc(1'b1, 32'd3, 32'd3, 32'd7, 2'd0, 1'b1, 1'b1);
        cyc(1'b1, 32'd5, 32'd5, 32'd0, 2'd0, 1'b1, 1'b0);
        cyc(1'b1, 32'd6, 32'd6, 32'd0, 2'd0, 1'b1, 1'b0);
        chk("rst_pre_d", d, 32'd16);
        rst = 1'b0;
        in_valid = 1'b0;
        #1;
        chk("rst_in_ready", {31'd0, in_ready}, 32'd0);
        idle();
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_d", d, 32'd0);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("rst_no_partial", {31'd0, out_valid}, 32'd0);
        end
        cyc(1'b1, 32'd2, 32'd2, 32'd0, 2'd0, 1'b1, 1'b0);
        idle();
        idle();
        chk("rst_acc_cleared_valid", {31'd0, out_valid}, 32'd1);
        chk("rst_acc_cleared", d, 32'd4);
        idle();

        // Wraparound
        cyc(1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h2, 2'd0, 1'b0, 1'b0);
        idle();
        idle();
        chk("wrap_d", d, 32'h3);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
